game_turn_sequencer: RTL and testbench
======================================

# game_turn_sequencer

Turn-based game controller that sits between the dice-recognition front end and `UI_Game_Renderer`. It accepts one die roll per turn and advances the active player's tile index. It issues `pos_valid` with the updated target x coordinates and waits for the renderer's `turn_done`. It then applies the question-box bonus, detects the winner, and hands the turn to the other player.

## Interface
- `NUM_TILES`, 10: tiles 0..NUM_TILES-1; the last tile is the finish.
- `TILE_X0`, 20: x coordinate of tile 0.
- `TILE_STEP`, 60: pixel pitch between tiles (tile n → TILE_X0 + n·TILE_STEP).
- `BONUS_MASK`, 10'b01_0101_0100: bit n set → tile n holds a question box (tiles 2, 4, 6, 8).
- `DONE_TIMEOUT`, 24'd12_500_000: cycles to wait for `turn_done` before forcing progress.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `dice_valid`  in  1  one-cycle pulse; `dice_value` is valid.
- `dice_value`  in  3  roll result, legal range 1..6.
- `turn_done`  in  1  one-cycle pulse from the renderer: movement animation finished.
- `new_game`  in  1  one-cycle pulse; restarts the game from WIN.
- `player1_pos_x`  out  10  player 1 target x.
- `player2_pos_x`  out  10  player 2 target x.
- `pos_valid`  out  1  one-cycle pulse; positions are updated.
- `active_player`  out  1  0 = player 1, 1 = player 2.
- `winner_valid`  out  1  level; a winner exists.
- `winner_id`  out  1  winning player; valid while `winner_valid` = 1.
- `busy`  out  1  high in every state except IDLE and WIN.
- `timeout_err`  out  1  sticky; set when a `turn_done` wait expires, cleared by `new_game`.

## Operation
- **States:** IDLE, MOVE, WAIT_DONE, BONUS, CHECK, SWITCH, WIN.
- **IDLE:** waits for `dice_valid`.
  - `dice_value` in 1..6: new tile = min(tile[active] + dice_value, NUM_TILES-1); go to MOVE.
  - `dice_value` of 0 or 7: pulse ignored, stay in IDLE.
- **MOVE:** drives `pos_valid` = 1 for exactly one cycle. Both `*_pos_x` outputs already hold the new value in that cycle. Go to WAIT_DONE.
- **WAIT_DONE:** leaves on `turn_done` or when the timeout counter reaches DONE_TIMEOUT-1 (which also sets `timeout_err`).
  - Next state is BONUS if the bonus is not yet used this turn; otherwise CHECK.
- **BONUS:** if BONUS_MASK[tile] = 1 and tile < NUM_TILES-1: tile += 1, mark the bonus used, go to MOVE. Otherwise go to CHECK.
  - At most one bonus per turn.
- **CHECK:** if tile = NUM_TILES-1, go to WIN; otherwise go to SWITCH.
- **SWITCH:** toggle `active_player`, clear the bonus-used flag, go to IDLE.
- **WIN:** `winner_valid` = 1, `winner_id` = `active_player`; rolls are ignored.
  - `new_game` resets both tiles to 0, `active_player` to 0, clears `winner_valid` and `timeout_err`, and goes to IDLE.
  - `new_game` is ignored in all other states.
- Pulses on `turn_done` outside WAIT_DONE and on `dice_valid` outside IDLE are dropped and have no effect.
- **Arithmetic:** tile registers are 4-bit and the sum is computed at 4 bits before clamping. Maximum raw sum is 9+6 = 15, so no overflow. x = TILE_X0 + tile·TILE_STEP, truncated to 10 bits (max 560).

## Timing
- **Reset values:** state IDLE, tiles 0, `player*_pos_x` = TILE_X0 (20), `pos_valid` 0, `active_player` 0, `winner_valid` 0, `winner_id` 0, `busy` 0, `timeout_err` 0.
- All outputs are registered.
- `dice_valid` at cycle t → `pos_valid` high at t+1.
- `turn_done` at cycle t → BONUS at t+1.
  - Bonus taken: second `pos_valid` at t+2.
  - No bonus: CHECK at t+2; then SWITCH and `active_player` toggling at t+4, or WIN with `winner_valid` high at t+3.
- The timeout counter resets on entry to WAIT_DONE. With `turn_done` and the timeout in the same cycle, `turn_done` wins and `timeout_err` is not set.
- Reset asserted mid-turn: all state returns to reset values immediately (asynchronous). Release is synchronous to `clk`.

## Structure
- Shared package `game_pkg`: state enum `turn_state_t`, plus defaults for NUM_TILES, TILE_X0, TILE_STEP, BONUS_MASK and DONE_TIMEOUT. The top level and renderer-side tile constants (question-box x = 140/260/380/500) are derived from the same package.
- One combinational sub-module, `tile_to_x`: tile index → x coordinate. Instantiate it twice, once per player.

## Test plan
- **Plain roll:** after reset, roll 3 → one `pos_valid` pulse with `player1_pos_x` = 200, `player2_pos_x` = 20. After `turn_done`, `active_player` = 1 and there is no second pulse.
- **Bonus:** P1 rolls 2 → pulse with x = 140. After `turn_done`, a second pulse with x = 200. After the second `turn_done`, `active_player` = 1.
- **Win with clamp:** P1 on tile 7 rolls 6 → x = 560, no bonus, `winner_valid` = 1, `winner_id` = 0. Further rolls ignored. `new_game` → both x = 20, `active_player` = 0.
- **Illegal and stray inputs:** `dice_value` 0 or 7 → no `pos_valid`. `dice_valid` during WAIT_DONE ignored. `turn_done` in IDLE ignored.
- **Timeout:** withhold `turn_done` for DONE_TIMEOUT cycles (bench sets it to 16) → `timeout_err` = 1 and the turn passes to player 2.
- **Reset mid-turn:** assert `rst_n` low during WAIT_DONE → outputs return to reset values immediately, and the next roll applies to player 1.

Source files
------------

// File: rtl/game_pkg.sv
// ============================================================================
// Module      : game_pkg
// Description : Shared types and board constants for the turn sequencer and
//               the renderer-side tile geometry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

  localparam int          DEF_NUM_TILES    = 10;
  localparam int          DEF_TILE_X0      = 20;
  localparam int          DEF_TILE_STEP    = 60;
  localparam logic [9:0]  DEF_BONUS_MASK   = 10'b01_0101_0100;
  localparam logic [23:0] DEF_DONE_TIMEOUT = 24'd12_500_000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MOVE      = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_BONUS     = 3'd3,
    ST_CHECK     = 3'd4,
    ST_SWITCH    = 3'd5,
    ST_WIN       = 3'd6
  } turn_state_t;

  function automatic int tile_x(input int n);
    return DEF_TILE_X0 + n * DEF_TILE_STEP;
  endfunction

  // Question-box x positions used by the renderer (tiles 2, 4, 6, 8)
  localparam int QBOX_X0 = tile_x(2);
  localparam int QBOX_X1 = tile_x(4);
  localparam int QBOX_X2 = tile_x(6);
  localparam int QBOX_X3 = tile_x(8);

endpackage

`default_nettype wire

// File: rtl/tile_to_x.sv
// ============================================================================
// Module      : tile_to_x
// Description : Combinational tile index to screen x coordinate (10 bits).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_to_x
  import game_pkg::*;
#(
  parameter int TILE_X0   = DEF_TILE_X0,
  parameter int TILE_STEP = DEF_TILE_STEP
) (
  input  logic [3:0] tile,
  output logic [9:0] x
);

  // Modulo-1024 arithmetic gives the required 10-bit truncation directly
  assign x = 10'(TILE_X0) + 10'(tile) * 10'(TILE_STEP);

endmodule

`default_nettype wire

// File: rtl/game_turn_sequencer.sv
// ============================================================================
// Module      : game_turn_sequencer
// Description : Two-player turn controller: dice roll -> move -> renderer
//               handshake -> question-box bonus -> win check -> next player.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_turn_sequencer
  import game_pkg::*;
#(
  parameter int                   NUM_TILES    = DEF_NUM_TILES,
  parameter int                   TILE_X0      = DEF_TILE_X0,
  parameter int                   TILE_STEP    = DEF_TILE_STEP,
  parameter logic [NUM_TILES-1:0] BONUS_MASK   = DEF_BONUS_MASK,
  parameter logic [23:0]          DONE_TIMEOUT = DEF_DONE_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dice_valid,
  input  logic [2:0] dice_value,
  input  logic       turn_done,
  input  logic       new_game,
  output logic [9:0] player1_pos_x,
  output logic [9:0] player2_pos_x,
  output logic       pos_valid,
  output logic       active_player,
  output logic       winner_valid,
  output logic       winner_id,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [3:0] c_LAST_TILE = 4'(NUM_TILES - 1);

  turn_state_t r_state, w_state_nxt;
  logic [3:0]  r_tile1, r_tile2, w_tile1_nxt, w_tile2_nxt;
  logic [3:0]  w_tile_cur, w_tile_new, w_sum;
  logic        w_tile_wr;
  logic        r_active, w_active_nxt;
  logic        r_bonus_used, w_bonus_used_nxt;
  logic [23:0] r_timer, w_timer_nxt;
  logic        r_pos_valid, w_pos_valid_nxt;
  logic        r_winner_valid, w_winner_valid_nxt;
  logic        r_winner_id, w_winner_id_nxt;
  logic        r_timeout_err, w_timeout_err_nxt;
  logic        r_busy, w_busy_nxt;
  logic [9:0]  r_p1_x, r_p2_x, w_p1_x, w_p2_x;

  assign w_tile_cur = r_active ? r_tile2 : r_tile1;
  assign w_sum      = w_tile_cur + {1'b0, dice_value};

  always_comb begin
    w_state_nxt        = r_state;
    w_tile1_nxt        = r_tile1;
    w_tile2_nxt        = r_tile2;
    w_tile_new         = w_tile_cur;
    w_tile_wr          = 1'b0;
    w_active_nxt       = r_active;
    w_bonus_used_nxt   = r_bonus_used;
    w_timer_nxt        = r_timer;
    w_pos_valid_nxt    = 1'b0;
    w_winner_valid_nxt = r_winner_valid;
    w_winner_id_nxt    = r_winner_id;
    w_timeout_err_nxt  = r_timeout_err;

    case (r_state)
      ST_IDLE: begin
        if (dice_valid && (dice_value != 3'd0) && (dice_value != 3'd7)) begin
          w_tile_new      = (w_sum > c_LAST_TILE) ? c_LAST_TILE : w_sum;
          w_tile_wr       = 1'b1;
          w_pos_valid_nxt = 1'b1;
          w_state_nxt     = ST_MOVE;
        end
      end
      ST_MOVE: begin
        w_timer_nxt = 24'd0;
        w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // turn_done takes priority over a coincident timeout
        if (turn_done) begin
          w_state_nxt = r_bonus_used ? ST_CHECK : ST_BONUS;
        end else if (r_timer == DONE_TIMEOUT - 24'd1) begin
          w_timeout_err_nxt = 1'b1;
          w_state_nxt       = r_bonus_used ? ST_CHECK : ST_BONUS;
        end else begin
          w_timer_nxt = r_timer + 24'd1;
        end
      end
      ST_BONUS: begin
        if (BONUS_MASK[w_tile_cur] && (w_tile_cur < c_LAST_TILE)) begin
          w_tile_new       = w_tile_cur + 4'd1;
          w_tile_wr        = 1'b1;
          w_bonus_used_nxt = 1'b1;
          w_pos_valid_nxt  = 1'b1;
          w_state_nxt      = ST_MOVE;
        end else begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_tile_cur == c_LAST_TILE) begin
          w_winner_valid_nxt = 1'b1;
          w_winner_id_nxt    = r_active;
          w_state_nxt        = ST_WIN;
        end else begin
          w_state_nxt = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        w_active_nxt     = ~r_active;
        w_bonus_used_nxt = 1'b0;
        w_state_nxt      = ST_IDLE;
      end
      ST_WIN: begin
        if (new_game) begin
          w_tile1_nxt        = 4'd0;
          w_tile2_nxt        = 4'd0;
          w_active_nxt       = 1'b0;
          w_bonus_used_nxt   = 1'b0;
          w_winner_valid_nxt = 1'b0;
          w_winner_id_nxt    = 1'b0;
          w_timeout_err_nxt  = 1'b0;
          w_state_nxt        = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_tile_wr) begin
      if (r_active) w_tile2_nxt = w_tile_new;
      else          w_tile1_nxt = w_tile_new;
    end
  end

  assign w_busy_nxt = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_WIN);

  // Positions are converted from next-state tiles so the x outputs are registered
  tile_to_x #(.TILE_X0(TILE_X0), .TILE_STEP(TILE_STEP)) u_p1_x (
    .tile (w_tile1_nxt),
    .x    (w_p1_x)
  );

  tile_to_x #(.TILE_X0(TILE_X0), .TILE_STEP(TILE_STEP)) u_p2_x (
    .tile (w_tile2_nxt),
    .x    (w_p2_x)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_tile1        <= 4'd0;
      r_tile2        <= 4'd0;
      r_active       <= 1'b0;
      r_bonus_used   <= 1'b0;
      r_timer        <= 24'd0;
      r_pos_valid    <= 1'b0;
      r_winner_valid <= 1'b0;
      r_winner_id    <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_busy         <= 1'b0;
      r_p1_x         <= 10'(TILE_X0);
      r_p2_x         <= 10'(TILE_X0);
    end else begin
      r_state        <= w_state_nxt;
      r_tile1        <= w_tile1_nxt;
      r_tile2        <= w_tile2_nxt;
      r_active       <= w_active_nxt;
      r_bonus_used   <= w_bonus_used_nxt;
      r_timer        <= w_timer_nxt;
      r_pos_valid    <= w_pos_valid_nxt;
      r_winner_valid <= w_winner_valid_nxt;
      r_winner_id    <= w_winner_id_nxt;
      r_timeout_err  <= w_timeout_err_nxt;
      r_busy         <= w_busy_nxt;
      r_p1_x         <= w_p1_x;
      r_p2_x         <= w_p2_x;
    end
  end

  assign player1_pos_x = r_p1_x;
  assign player2_pos_x = r_p2_x;
  assign pos_valid     = r_pos_valid;
  assign active_player = r_active;
  assign winner_valid  = r_winner_valid;
  assign winner_id     = r_winner_id;
  assign busy          = r_busy;
  assign timeout_err   = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_game_turn_sequencer.sv
// ============================================================================
// Module      : tb_game_turn_sequencer
// Description : Scoreboard bench for game_turn_sequencer with directed turns.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_turn_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dice_valid;
  logic [2:0] dice_value;
  logic       turn_done;
  logic       new_game;
  logic [9:0] player1_pos_x, player2_pos_x;
  logic       pos_valid, active_player, winner_valid, winner_id, busy, timeout_err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [9:0] p1;
    logic [9:0] p2;
  } exp_t;

  exp_t exp_q[$];

  game_turn_sequencer #(.DONE_TIMEOUT(24'd16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dice_valid    (dice_valid),
    .dice_value    (dice_value),
    .turn_done     (turn_done),
    .new_game      (new_game),
    .player1_pos_x (player1_pos_x),
    .player2_pos_x (player2_pos_x),
    .pos_valid     (pos_valid),
    .active_player (active_player),
    .winner_valid  (winner_valid),
    .winner_id     (winner_id),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every pos_valid pulse must match the next queued expectation
  always @(negedge clk) begin
    if (rst_n && pos_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pos_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pos_p1_x", int'(player1_pos_x), int'(e.p1));
        check("pos_p2_x", int'(player2_pos_x), int'(e.p2));
      end
    end
  end

  task automatic push(input int p1, input int p2);
    exp_t e;
    e.p1 = 10'(p1);
    e.p2 = 10'(p2);
    exp_q.push_back(e);
  endtask

  task automatic roll(input logic [2:0] v);
    @(posedge clk); #1;
    dice_valid = 1'b1; dice_value = v;
    @(posedge clk); #1;
    dice_valid = 1'b0; dice_value = 3'd0;
  endtask

  task automatic done_pulse();
    @(posedge clk); #1;
    turn_done = 1'b1;
    @(posedge clk); #1;
    turn_done = 1'b0;
  endtask

  task automatic wait_pos();
    int n = 0;
    do begin @(negedge clk); n++; end while (!pos_valid && n < 40);
    check("pos_valid_seen", int'(pos_valid), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < budget);
    check("idle_reached", int'(busy), 0);
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  // One full turn without bonus
  task automatic play(input logic [2:0] v, input int p1, input int p2);
    push(p1, p2);
    roll(v);
    wait_pos();
    done_pulse();
    wait_idle(40);
  endtask

  // One turn landing on a question box: two position updates
  task automatic play_bonus(input logic [2:0] v, input int a1, input int a2,
                            input int b1, input int b2);
    push(a1, a2);
    push(b1, b2);
    roll(v);
    wait_pos();
    done_pulse();
    wait_pos();
    done_pulse();
    wait_idle(40);
  endtask

  initial begin
    rst_n = 1'b0; dice_valid = 1'b0; dice_value = 3'd0;
    turn_done = 1'b0; new_game = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    idle_cycles(1);

    // Reset state
    check("rst_p1_x", int'(player1_pos_x), 20);
    check("rst_p2_x", int'(player2_pos_x), 20);
    check("rst_pos_valid", int'(pos_valid), 0);
    check("rst_active", int'(active_player), 0);
    check("rst_winner_valid", int'(winner_valid), 0);
    check("rst_winner_id", int'(winner_id), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_timeout", int'(timeout_err), 0);

    // Plain roll: P1 tile 0 -> 3
    play(3'd3, 200, 20);
    idle_cycles(3);
    check("plain_active", int'(active_player), 1);
    check("plain_queue_empty", exp_q.size(), 0);

    // Stray turn_done in IDLE, illegal dice values
    done_pulse();
    roll(3'd0);
    roll(3'd7);
    idle_cycles(3);
    check("stray_busy", int'(busy), 0);
    check("stray_active", int'(active_player), 1);
    check("stray_p2_x", int'(player2_pos_x), 20);

    // P2 rolls 1; a roll during WAIT_DONE is dropped
    push(200, 80);
    roll(3'd1);
    wait_pos();
    roll(3'd5);
    done_pulse();
    wait_idle(40);
    check("p2_x_after_drop", int'(player2_pos_x), 80);
    check("p2_turn_active", int'(active_player), 0);

    // P1 tile 3 rolls 1 -> tile 4 (box) -> tile 5
    play_bonus(3'd1, 260, 80, 320, 80);
    check("bonus_active", int'(active_player), 1);
    check("bonus_queue_empty", exp_q.size(), 0);

    // March to a clamped win: P2 1->3, P1 5->7, P2 3->5, P1 7+6 -> 9
    play(3'd2, 320, 200);
    play(3'd2, 440, 200);
    play(3'd2, 440, 320);
    play(3'd6, 560, 320);
    check("win_valid", int'(winner_valid), 1);
    check("win_id", int'(winner_id), 0);
    check("win_active", int'(active_player), 0);
    check("win_busy", int'(busy), 0);
    roll(3'd4);
    idle_cycles(4);
    check("win_roll_ignored_x", int'(player1_pos_x), 560);
    check("win_roll_ignored_q", exp_q.size(), 0);
    @(posedge clk); #1 new_game = 1'b1;
    @(posedge clk); #1 new_game = 1'b0;
    idle_cycles(2);
    check("ng_p1_x", int'(player1_pos_x), 20);
    check("ng_p2_x", int'(player2_pos_x), 20);
    check("ng_active", int'(active_player), 0);
    check("ng_winner_valid", int'(winner_valid), 0);

    // Timeout: no turn_done for P1's roll of 1
    push(80, 20);
    roll(3'd1);
    wait_pos();
    idle_cycles(5);
    check("to_still_busy", int'(busy), 1);
    check("to_not_yet", int'(timeout_err), 0);
    wait_idle(60);
    check("to_err", int'(timeout_err), 1);
    check("to_active", int'(active_player), 1);

    // Reset during WAIT_DONE of P2's roll of 3
    push(80, 200);
    roll(3'd3);
    wait_pos();
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("mid_rst_p1_x", int'(player1_pos_x), 20);
    check("mid_rst_p2_x", int'(player2_pos_x), 20);
    check("mid_rst_active", int'(active_player), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_timeout", int'(timeout_err), 0);
    @(negedge clk) rst_n = 1'b1;

    // Next roll goes to P1: tile 0 -> 2 (box) -> 3
    play_bonus(3'd2, 140, 20, 200, 20);
    check("post_rst_active", int'(active_player), 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
